lcd_cls_command_sequencer: RTL and testbench

// - Serves the LCD feed's clear/line1/line2 write strobes; asserts/drops o_lcd_command_ready per the feed's ready/busy handshake.
// - Expands each accepted command into the PMOD CLS ANSI byte sequence and hands bytes one at a time to the SPI byte transmitter.
// - Sits between the LCD text feed FSM and the SPI byte transmitter; runs only on i_ce_2_5mhz cycles.

---
 rtl/lcd_cls_pkg.sv | 37 +++
 rtl/lcd_cls_seq_rom.sv | 41 ++++
 rtl/lcd_cls_command_sequencer.sv | 129 ++++++++++++
 tb/tb_lcd_cls_command_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_cls_pkg.sv
// Shared types and constants for the PMOD CLS command sequencer.
package lcd_cls_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_SPI,
        ST_DONE
    } t_lcd_seq_state;

    typedef enum logic [1:0] {
        CMD_CLEAR,
        CMD_LINE1,
        CMD_LINE2
    } t_lcd_cmd;

    // ANSI escape bytes understood by the PMOD CLS
    localparam logic [7:0] ANSI_ESC      = 8'h1B;
    localparam logic [7:0] ANSI_LBRACKET = 8'h5B;
    localparam logic [7:0] ANSI_J        = 8'h6A;
    localparam logic [7:0] ANSI_SEMI     = 8'h3B;
    localparam logic [7:0] ANSI_H        = 8'h48;
    localparam logic [7:0] ANSI_0        = 8'h30;
    localparam logic [7:0] ANSI_1        = 8'h31;

    // Clear is ESC [ j; a line write is ESC [ row ; 0 H followed by the text
    localparam int SEQ_LEN_CLEAR = 3;
    localparam int LINE_HDR_LEN  = 6;
    localparam int SEQ_LEN_LINE  = 22;

    // Index of the final byte of a command's sequence
    function automatic logic [4:0] seq_last_idx(input t_lcd_cmd cmd, input int text_chars);
        if (cmd == CMD_CLEAR) return 5'(SEQ_LEN_CLEAR - 1);
        return 5'(LINE_HDR_LEN + text_chars - 1);
    endfunction

endpackage

// File: rtl/lcd_cls_seq_rom.sv
// Combinational byte lookup: (command, byte index, latched text) -> ANSI byte.
module lcd_cls_seq_rom
    import lcd_cls_pkg::*;
#(
    parameter int parm_text_chars = 16
) (
    input  t_lcd_cmd                         cmd,
    input  logic [4:0]                       idx,
    input  logic [8*parm_text_chars-1:0]     text,
    output logic [7:0]                       seq_byte
);

    // Header bytes are constants; text bytes go out char 0 (MSB) first
    always_comb begin
        seq_byte = 8'h00;
        if (cmd == CMD_CLEAR) begin
            case (idx)
                5'd0:    seq_byte = ANSI_ESC;
                5'd1:    seq_byte = ANSI_LBRACKET;
                5'd2:    seq_byte = ANSI_J;
                default: seq_byte = 8'h00;
            endcase
        end else begin
            case (idx)
                5'd0:    seq_byte = ANSI_ESC;
                5'd1:    seq_byte = ANSI_LBRACKET;
                5'd2:    seq_byte = (cmd == CMD_LINE1) ? ANSI_0 : ANSI_1;
                5'd3:    seq_byte = ANSI_SEMI;
                5'd4:    seq_byte = ANSI_0;
                5'd5:    seq_byte = ANSI_H;
                default: begin
                    for (int i = 0; i < parm_text_chars; i++) begin
                        if (int'(idx) == LINE_HDR_LEN + i)
                            seq_byte = text[8*(parm_text_chars-1-i) +: 8];
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_cls_command_sequencer.sv
// Accepts clear/line1/line2 requests from the LCD text feed and streams the
// matching PMOD CLS ANSI byte sequence to the SPI byte transmitter.
module lcd_cls_command_sequencer
    import lcd_cls_pkg::*;
#(
    parameter int parm_text_chars = 16
) (
    input  logic                         i_clk_20mhz,
    input  logic                         i_rst_20mhz,
    input  logic                         i_ce_2_5mhz,
    input  logic                         i_lcd_wr_clear_display,
    input  logic                         i_lcd_wr_text_line1,
    input  logic                         i_lcd_wr_text_line2,
    input  logic [8*parm_text_chars-1:0] i_dat_ascii_line1,
    input  logic [8*parm_text_chars-1:0] i_dat_ascii_line2,
    output logic                         o_lcd_command_ready,
    output logic [7:0]                   o_tx_byte,
    output logic                         o_tx_valid,
    input  logic                         i_tx_ready,
    input  logic                         i_spi_idle
);

    localparam int TW = 8 * parm_text_chars;

    t_lcd_seq_state state_q, state_d;
    t_lcd_cmd       cmd_q, cmd_d;
    logic [4:0]     idx_q, idx_d;
    logic [TW-1:0]  text_q, text_d;
    logic           ready_q, ready_d;
    logic           tx_valid_q, tx_valid_d;
    logic [7:0]     tx_byte_q, tx_byte_d;

    logic [7:0]     rom_byte;
    logic [4:0]     last_idx;

    assign last_idx = seq_last_idx(cmd_q, parm_text_chars);

    lcd_cls_seq_rom #(
        .parm_text_chars (parm_text_chars)
    ) u_rom (
        .cmd      (cmd_q),
        .idx      (idx_q),
        .text     (text_q),
        .seq_byte (rom_byte)
    );

    // Next-state logic. In ST_SEND a byte is loaded on one CE and, once taken,
    // valid is dropped for a CE so the same byte can never be accepted twice.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        text_d     = text_q;
        ready_d    = ready_q;
        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        case (state_q)
            ST_IDLE: begin
                if (i_lcd_wr_clear_display || i_lcd_wr_text_line1 || i_lcd_wr_text_line2) begin
                    if (i_lcd_wr_clear_display) begin
                        cmd_d  = CMD_CLEAR;
                        text_d = '0;
                    end else if (i_lcd_wr_text_line1) begin
                        cmd_d  = CMD_LINE1;
                        text_d = i_dat_ascii_line1;
                    end else begin
                        cmd_d  = CMD_LINE2;
                        text_d = i_dat_ascii_line2;
                    end
                    idx_d      = 5'd0;
                    tx_valid_d = 1'b0;
                    ready_d    = 1'b0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_valid_q) begin
                    tx_byte_d  = rom_byte;
                    tx_valid_d = 1'b1;
                end else if (i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (idx_q == last_idx) begin
                        idx_d   = 5'd0;
                        state_d = ST_WAIT_SPI;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_WAIT_SPI: begin
                if (i_spi_idle) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State register; every update waits for the 2.5 MHz clock enable
    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_CLEAR;
            idx_q      <= 5'd0;
            text_q     <= '0;
            ready_q    <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else if (i_ce_2_5mhz) begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            text_q     <= text_d;
            ready_q    <= ready_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign o_lcd_command_ready = ready_q;
    assign o_tx_valid          = tx_valid_q;
    assign o_tx_byte           = tx_byte_q;

endmodule

// File: tb/tb_lcd_cls_command_sequencer.sv
// Bench for lcd_cls_command_sequencer: table of commands plus random commands,
// byte stream checked against a sequence-level model.
module tb_lcd_cls_command_sequencer;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic         clr;
        logic         l1;
        logic         l2;
        logic [127:0] t1;
        logic [127:0] t2;
        int           exp_len;
        logic [7:0]   exp_b2;
        int           stall_at;
        int           stall_len;
        logic         hold_l2;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ce = 1'b0;
    logic         req_clr = 1'b0, req_l1 = 1'b0, req_l2 = 1'b0;
    logic [127:0] dat1 = '0, dat2 = '0;
    logic         ready;
    logic [7:0]   tx_byte;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         spi_idle = 1'b0;

    int   n_chk = 0;
    int   n_fail = 0;
    bq_t  got;

    lcd_cls_command_sequencer #(.parm_text_chars(16)) dut (
        .i_clk_20mhz            (clk),
        .i_rst_20mhz            (rst),
        .i_ce_2_5mhz            (ce),
        .i_lcd_wr_clear_display (req_clr),
        .i_lcd_wr_text_line1    (req_l1),
        .i_lcd_wr_text_line2    (req_l2),
        .i_dat_ascii_line1      (dat1),
        .i_dat_ascii_line2      (dat2),
        .o_lcd_command_ready    (ready),
        .o_tx_byte              (tx_byte),
        .o_tx_valid             (tx_valid),
        .i_tx_ready             (tx_ready),
        .i_spi_idle             (spi_idle)
    );

    always #25 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Expected byte stream of a request set, from the command definitions
    function automatic bq_t model(input logic c, input logic l1, input logic l2,
                                  input logic [127:0] t1, input logic [127:0] t2);
        bq_t q;
        logic [127:0] t;
        logic [7:0] row;
        q = {};
        if (c) begin
            q = '{8'h1B, 8'h5B, 8'h6A};
            return q;
        end
        if (l1) begin row = 8'h30; t = t1; end
        else    begin row = 8'h31; t = t2; end
        q = '{8'h1B, 8'h5B, row, 8'h3B, 8'h30, 8'h48};
        for (int i = 0; i < 16; i++) q.push_back(t[127-8*i -: 8]);
        return q;
    endfunction

    // Transmitter-side monitor: records accepted bytes, checks hold under stall
    // and that an accepted byte is never offered again on the next CE.
    logic       m_prev_stall = 1'b0;
    logic       m_prev_acc = 1'b0;
    logic [7:0] m_prev_byte = 8'h00;
    always @(posedge clk) begin
        if (rst) begin
            m_prev_stall = 1'b0;
            m_prev_acc   = 1'b0;
        end else if (ce) begin
            if (m_prev_stall) begin
                n_chk++;
                if (!(tx_valid === 1'b1 && tx_byte === m_prev_byte)) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%0b byte=%0h expected valid=1 byte=%0h",
                             tx_valid, tx_byte, m_prev_byte);
                end
            end
            if (m_prev_acc) begin
                n_chk++;
                if (tx_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap_after_accept: got valid=%0b expected 0", tx_valid);
                end
            end
            m_prev_acc   = tx_valid && tx_ready;
            m_prev_stall = tx_valid && !tx_ready;
            m_prev_byte  = tx_byte;
            if (m_prev_acc) got.push_back(tx_byte);
        end
    end

    // One CE period: one CE-qualified posedge and two ordinary posedges
    task automatic tick();
        @(negedge clk); ce = 1'b1;
        @(negedge clk); ce = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_cmd(input logic c, input logic l1, input logic l2,
                           input logic [127:0] t1, input logic [127:0] t2,
                           input int stall_at, input int stall_len, input logic hold_l2,
                           input logic rnd, input int exp_len, input logic [7:0] exp_b2);
        bq_t exp_q;
        int  t, scnt, nbad;
        exp_q = model(c, l1, l2, t1, t2);
        got.delete();
        tx_ready = 1'b0;
        spi_idle = 1'b0;
        chk("ready_before", int'(ready), 1);
        req_clr = c; req_l1 = l1; req_l2 = l2;
        dat1 = t1; dat2 = t2;
        tick();
        req_clr = 1'b0; req_l1 = 1'b0;
        if (!hold_l2) req_l2 = 1'b0;
        chk("ready_drop", int'(ready), 0);
        t = 0; scnt = 0;
        while (got.size() < exp_q.size() && t < 400) begin
            dat1 = {$urandom, $urandom, $urandom, $urandom};
            dat2 = {$urandom, $urandom, $urandom, $urandom};
            if (stall_at >= 0 && got.size() == stall_at && scnt < stall_len && tx_valid) begin
                tx_ready = 1'b0;
                scnt++;
            end else begin
                tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            tick();
            t++;
        end
        tx_ready = 1'b0;
        chk("seq_timeout", int'(t < 400), 1);
        chk("seq_len", got.size(), exp_q.size());
        nbad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
        chk("seq_bytes", nbad, 0);
        if (exp_len >= 0) begin
            chk("tbl_len", got.size(), exp_len);
            chk("tbl_b2", (got.size() > 2) ? int'(got[2]) : -1, int'(exp_b2));
        end
        if (stall_at >= 0 && stall_at < exp_q.size()) chk("stall_count", scnt, stall_len);
        repeat (3) tick();
        chk("valid_after_last", int'(tx_valid), 0);
        chk("ready_wait_spi", int'(ready), 0);
        spi_idle = 1'b1;
        tick();
        chk("ready_done_cycle", int'(ready), 0);
        tick();
        chk("ready_back", int'(ready), 1);
        chk("extra_bytes", got.size(), exp_q.size());
    endtask

    localparam logic [127:0] T_ACL  = "ACL TESTER  0001";
    localparam logic [127:0] T_LN2  = "LINE TWO 0123456";
    localparam logic [127:0] T_NP   = 128'h00011F7F80FF0A0D1B5B48306A3B3109;

    vec_t vecs[6];

    initial begin
        int t;
        vecs[0] = '{1'b1, 1'b0, 1'b0, T_ACL, T_LN2, 3,  8'h6A, -1, 0,  1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, T_ACL, T_LN2, 22, 8'h30, -1, 0,  1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, T_ACL, T_LN2, 22, 8'h31, 7,  10, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, T_ACL, T_LN2, 3,  8'h6A, -1, 0,  1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, T_NP,  T_LN2, 22, 8'h30, 3,  2,  1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, T_ACL, T_NP,  22, 8'h31, -1, 0,  1'b0};

        // Reset values, then CE cycles during reset must not move anything
        repeat (2) tick();
        chk("rst_ready", int'(ready), 1);
        chk("rst_valid", int'(tx_valid), 0);
        chk("rst_byte", int'(tx_byte), 0);
        @(negedge clk); rst = 1'b0;
        tick();
        chk("idle_ready", int'(ready), 1);
        chk("idle_valid", int'(tx_valid), 0);

        // Table of directed commands
        for (int v = 0; v < 6; v++) begin
            run_cmd(vecs[v].clr, vecs[v].l1, vecs[v].l2, vecs[v].t1, vecs[v].t2,
                    vecs[v].stall_at, vecs[v].stall_len, vecs[v].hold_l2, 1'b0,
                    vecs[v].exp_len, vecs[v].exp_b2);
            if (vecs[v].hold_l2) begin
                // Line 2 was still held, so it is a fresh command once ready returns
                run_cmd(1'b0, 1'b0, 1'b1, vecs[v].t1, vecs[v].t2, -1, 0, 1'b0, 1'b0, 22, 8'h31);
            end
        end

        // Async reset in the middle of a line 1 write
        got.delete();
        spi_idle = 1'b0;
        req_l1 = 1'b1; dat1 = T_ACL;
        tick();
        req_l1 = 1'b0;
        tx_ready = 1'b1;
        t = 0;
        while (got.size() < 10 && t < 200) begin tick(); t++; end
        chk("pre_reset_bytes", got.size(), 10);
        #7 rst = 1'b1;
        #1;
        chk("async_rst_ready", int'(ready), 1);
        chk("async_rst_valid", int'(tx_valid), 0);
        chk("async_rst_byte", int'(tx_byte), 0);
        repeat (2) tick();
        @(negedge clk); rst = 1'b0;
        got.delete();
        repeat (3) tick();
        chk("no_resend_after_rst", got.size(), 0);
        chk("ready_after_rst", int'(ready), 1);
        tx_ready = 1'b0;
        run_cmd(1'b1, 1'b0, 1'b0, '0, '0, -1, 0, 1'b0, 1'b0, 3, 8'h6A);

        // Random requests, random text and random transmitter backpressure
        for (int r = 0; r < 15; r++) begin
            logic [2:0] rq;
            logic [127:0] a, b;
            int sa;
            rq = 3'($urandom_range(1, 7));
            a  = {$urandom, $urandom, $urandom, $urandom};
            b  = {$urandom, $urandom, $urandom, $urandom};
            sa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 21)) : -1;
            run_cmd(rq[2], rq[1], rq[0], a, b, sa, int'($urandom_range(1, 5)), 1'b0, 1'b1, -1, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
